// File: rtl/ssd_pkg.sv
// Shared constants, FSM encoding and width helper for the 7-segment scan controller.
package ssd_pkg;

   localparam logic [6:0] SEG_OFF = 7'h7F;
   localparam logic [7:0] AN_OFF  = 8'hFF;

   typedef enum logic {
      ST_BLANK = 1'b0,
      ST_DRIVE = 1'b1
   } state_e;

   // Never returns less than 1 so a single-digit build still gets a real index register.
   function automatic int clog2(input int value);
      int w;
      w = 1;
      for (int i = 1; i < 31; i++) begin
         if ((1 << i) < value) w = i + 1;
      end
      return w;
   endfunction

endpackage

// File: rtl/ssd_scan_ctrl_if.sv
// Value-logic to scan-controller bus. SSD_BRIGHTNESS_EN adds the i_brightness input.
interface ssd_scan_ctrl_if #(
   parameter int NUM_DIGITS = 4
);
   logic [4*NUM_DIGITS-1:0] i_digits;
   logic [NUM_DIGITS-1:0]   i_dp;
   logic [NUM_DIGITS-1:0]   i_digit_en;
   logic                    i_load;
`ifdef SSD_BRIGHTNESS_EN
   logic [3:0]              i_brightness;
`endif
   logic [6:0]              o_seg;
   logic                    o_dp;
   logic [NUM_DIGITS-1:0]   o_an;
   logic                    o_frame_done;

   modport master (
`ifdef SSD_BRIGHTNESS_EN
      output i_brightness,
`endif
      output i_digits, i_dp, i_digit_en, i_load,
      input  o_seg, o_dp, o_an, o_frame_done
   );

   modport slave (
`ifdef SSD_BRIGHTNESS_EN
      input  i_brightness,
`endif
      input  i_digits, i_dp, i_digit_en, i_load,
      output o_seg, o_dp, o_an, o_frame_done
   );
endinterface

// File: rtl/ssd_hex_decode.sv
// Nibble to active-low {g,f,e,d,c,b,a} pattern, full hex set; purely combinational.
module ssd_hex_decode (
   input  logic [3:0] i_nib,
   output logic [6:0] o_seg
);
   always_comb begin
      o_seg = 7'h7F;
      case (i_nib)
         4'h0: o_seg = 7'h40;
         4'h1: o_seg = 7'h79;
         4'h2: o_seg = 7'h24;
         4'h3: o_seg = 7'h30;
         4'h4: o_seg = 7'h19;
         4'h5: o_seg = 7'h12;
         4'h6: o_seg = 7'h02;
         4'h7: o_seg = 7'h78;
         4'h8: o_seg = 7'h00;
         4'h9: o_seg = 7'h10;
         4'hA: o_seg = 7'h08;
         4'hB: o_seg = 7'h03;
         4'hC: o_seg = 7'h46;
         4'hD: o_seg = 7'h21;
         4'hE: o_seg = 7'h06;
         4'hF: o_seg = 7'h0E;
         default: o_seg = 7'h7F;
      endcase
   end
endmodule

// File: rtl/ssd_scan_ctrl.sv
// N-digit common-anode scan controller with double-buffered digit store and per-slot blanking.
// SSD_BRIGHTNESS_EN adds a 4-bit PWM dimmer on the anode drive.
module ssd_scan_ctrl
   import ssd_pkg::*;
#(
   parameter int NUM_DIGITS   = 4,
   parameter int SLOT_CYCLES  = 100000,
   parameter int BLANK_CYCLES = 2000
) (
   input  logic            i_clk,
   input  logic            i_rst,
   ssd_scan_ctrl_if.slave  bus
);
   localparam int CNT_W = clog2(SLOT_CYCLES);
   localparam int IDX_W = clog2(NUM_DIGITS);
   localparam logic [CNT_W-1:0] SLOT_LAST  = CNT_W'(SLOT_CYCLES - 1);
   localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'(BLANK_CYCLES - 1);
   localparam logic [IDX_W-1:0] IDX_LAST   = IDX_W'(NUM_DIGITS - 1);
   localparam logic [NUM_DIGITS-1:0] AN_ALL_OFF = AN_OFF[NUM_DIGITS-1:0];

   logic [CNT_W-1:0] slot_cnt_q, slot_cnt_d;
   logic [IDX_W-1:0] dig_idx_q, dig_idx_d;
   state_e           state_q, state_d;

   logic [NUM_DIGITS-1:0][3:0] stg_dig_q, stg_dig_d, act_dig_q, act_dig_d;
   logic [NUM_DIGITS-1:0]      stg_dp_q, stg_dp_d, act_dp_q, act_dp_d;
   logic [NUM_DIGITS-1:0]      stg_en_q, stg_en_d, act_en_q, act_en_d;

   logic [NUM_DIGITS-1:0] an_q, an_d;
   logic [6:0]            seg_q, seg_d;
   logic                  dp_q, dp_d;
   logic                  fd_q, fd_d;

   logic       slot_wrap;
   logic       frame_end;
   logic [3:0] cur_nib;
   logic [6:0] cur_seg;
   logic       pwm_on;

   assign slot_wrap = (slot_cnt_q == SLOT_LAST);
   assign frame_end = slot_wrap && (dig_idx_q == IDX_LAST);

`ifdef SSD_BRIGHTNESS_EN
   logic [3:0] pwm_cnt_q, pwm_cnt_d;
   assign pwm_cnt_d = pwm_cnt_q + 4'd1;
   // Full scale must be steady-on, which a plain compare against 15 cannot give.
   assign pwm_on = (bus.i_brightness == 4'hF) || (pwm_cnt_q < bus.i_brightness);

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) pwm_cnt_q <= 4'd0;
      else       pwm_cnt_q <= pwm_cnt_d;
   end
`else
   assign pwm_on = 1'b1;
`endif

   // Scan position and buffer swap
   always_comb begin
      slot_cnt_d = slot_wrap ? '0 : slot_cnt_q + CNT_W'(1);
      dig_idx_d  = dig_idx_q;
      if (slot_wrap) dig_idx_d = (dig_idx_q == IDX_LAST) ? '0 : dig_idx_q + IDX_W'(1);

      stg_dig_d = stg_dig_q;
      stg_dp_d  = stg_dp_q;
      stg_en_d  = stg_en_q;
      if (bus.i_load) begin
         stg_dig_d = bus.i_digits;
         stg_dp_d  = bus.i_dp;
         stg_en_d  = bus.i_digit_en;
      end

      act_dig_d = act_dig_q;
      act_dp_d  = act_dp_q;
      act_en_d  = act_en_q;
      if (frame_end) begin
         // A load landing on the boundary cycle bypasses the stage so it is not lost for a frame.
         act_dig_d = bus.i_load ? bus.i_digits   : stg_dig_q;
         act_dp_d  = bus.i_load ? bus.i_dp       : stg_dp_q;
         act_en_d  = bus.i_load ? bus.i_digit_en : stg_en_q;
      end
      fd_d = frame_end;
   end

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) state_q <= ST_BLANK;
      else       state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_BLANK: if (slot_cnt_q == BLANK_LAST) state_d = ST_DRIVE;
         ST_DRIVE: if (slot_wrap) state_d = ST_BLANK;
         default:  state_d = ST_BLANK;
      endcase
   end

   assign cur_nib = act_dig_q[dig_idx_q];

   ssd_hex_decode u_hex (
      .i_nib (cur_nib),
      .o_seg (cur_seg)
   );

   always_comb begin
      an_d  = AN_ALL_OFF;
      seg_d = SEG_OFF;
      dp_d  = 1'b1;
      if (state_q == ST_DRIVE && act_en_q[dig_idx_q]) begin
         an_d[dig_idx_q] = ~pwm_on;
         seg_d = cur_seg;
         dp_d  = ~act_dp_q[dig_idx_q];
      end
   end

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         slot_cnt_q <= '0;
         dig_idx_q  <= '0;
         stg_dig_q  <= '0;
         stg_dp_q   <= '0;
         stg_en_q   <= '0;
         act_dig_q  <= '0;
         act_dp_q   <= '0;
         act_en_q   <= '0;
         an_q       <= AN_ALL_OFF;
         seg_q      <= SEG_OFF;
         dp_q       <= 1'b1;
         fd_q       <= 1'b0;
      end else begin
         slot_cnt_q <= slot_cnt_d;
         dig_idx_q  <= dig_idx_d;
         stg_dig_q  <= stg_dig_d;
         stg_dp_q   <= stg_dp_d;
         stg_en_q   <= stg_en_d;
         act_dig_q  <= act_dig_d;
         act_dp_q   <= act_dp_d;
         act_en_q   <= act_en_d;
         an_q       <= an_d;
         seg_q      <= seg_d;
         dp_q       <= dp_d;
         fd_q       <= fd_d;
      end
   end

   assign bus.o_an         = an_q;
   assign bus.o_seg        = seg_q;
   assign bus.o_dp         = dp_q;
   assign bus.o_frame_done = fd_q;

endmodule

// File: tb/tb_ssd_scan_ctrl.sv
// Bench for ssd_scan_ctrl: table rows, directed buffering/reset sequences and a random load run against a frame-arithmetic model.
module tb_ssd_scan_ctrl;
   localparam int ND = 4;
   localparam int SC = 8;
   localparam int BC = 2;
   localparam int NS = ND * SC;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   ssd_scan_ctrl_if #(.NUM_DIGITS(ND)) bus ();

   ssd_scan_ctrl #(
      .NUM_DIGITS   (ND),
      .SLOT_CYCLES  (SC),
      .BLANK_CYCLES (BC)
   ) dut (
      .i_clk (clk),
      .i_rst (rst),
      .bus   (bus)
   );

`ifdef SSD_BRIGHTNESS_EN
   initial bus.i_brightness = 4'hF;
`endif

   typedef struct {
      logic [15:0]     dig;
      logic [3:0]      dp;
      logic [3:0]      en;
      logic [3:0][6:0] seg;
   } row_t;

   row_t rows [4];

   int n_checks = 0;
   int n_fail   = 0;
   int edges    = 0;

   logic [15:0] m_stg_dig, m_act_dig;
   logic [3:0]  m_stg_dp, m_act_dp, m_stg_en, m_act_en;

   function automatic logic [6:0] hex7(input logic [3:0] v);
      logic [6:0] t [16];
      t = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
            7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};
      return t[v];
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic model_reset();
      edges = 0;
      m_stg_dig = '0; m_act_dig = '0;
      m_stg_dp  = '0; m_act_dp  = '0;
      m_stg_en  = '0; m_act_en  = '0;
   endtask

   task automatic set_in(input logic [15:0] d, input logic [3:0] dp, input logic [3:0] en, input logic ld);
      bus.i_digits   = d;
      bus.i_dp       = dp;
      bus.i_digit_en = en;
      bus.i_load     = ld;
   endtask

   // One clock: predict from the frame position of the sampled counter, then compare at the falling edge.
   task automatic step();
      int c, pos, slot, dig;
      logic [3:0] e_an;
      logic [6:0] e_seg;
      logic e_dp, e_fd;
      @(posedge clk);
      edges++;
      c = edges - 1;
      pos = c % NS;
      slot = pos % SC;
      dig = pos / SC;
      e_an = 4'hF; e_seg = 7'h7F; e_dp = 1'b1;
      e_fd = (pos == NS - 1);
      if (slot >= BC && m_act_en[dig]) begin
         e_an  = ~(4'b0001 << dig);
         e_seg = hex7(m_act_dig[dig*4 +: 4]);
         e_dp  = ~m_act_dp[dig];
      end
      if (pos == NS - 1) begin
         m_act_dig = bus.i_load ? bus.i_digits   : m_stg_dig;
         m_act_dp  = bus.i_load ? bus.i_dp       : m_stg_dp;
         m_act_en  = bus.i_load ? bus.i_digit_en : m_stg_en;
      end
      if (bus.i_load) begin
         m_stg_dig = bus.i_digits;
         m_stg_dp  = bus.i_dp;
         m_stg_en  = bus.i_digit_en;
      end
      @(negedge clk);
      chk("scan", {19'd0, bus.o_an, bus.o_seg, bus.o_dp, bus.o_frame_done},
                  {19'd0, e_an, e_seg, e_dp, e_fd});
   endtask

   // Advance until the most recent step sampled frame position p.
   task automatic run_to(input int p);
      for (int i = 0; i < NS + 1; i++) begin
         if (edges > 0 && ((edges - 1) % NS) == p) break;
         step();
      end
   endtask

   task automatic load_pulse(input logic [15:0] d, input logic [3:0] dp, input logic [3:0] en);
      set_in(d, dp, en, 1'b1);
      step();
      bus.i_load = 1'b0;
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int lit, t0, t1;
      rows[0] = '{dig: 16'h3210, dp: 4'b0000, en: 4'hF, seg: {7'h30, 7'h24, 7'h79, 7'h40}};
      rows[1] = '{dig: 16'hFEDC, dp: 4'b0101, en: 4'hF, seg: {7'h0E, 7'h06, 7'h21, 7'h46}};
      rows[2] = '{dig: 16'h7654, dp: 4'b0000, en: 4'b1010, seg: {7'h78, 7'h02, 7'h12, 7'h19}};
      rows[3] = '{dig: 16'hBA98, dp: 4'b1010, en: 4'hF, seg: {7'h03, 7'h08, 7'h10, 7'h00}};

      rst = 1'b1;
      set_in('0, '0, '0, 1'b0);
      model_reset();
      #12;
      chk("reset_state", {bus.o_an, bus.o_seg, bus.o_dp, bus.o_frame_done}, {4'hF, 7'h7F, 1'b1, 1'b0});
      @(negedge clk);
      rst = 1'b0;

      // Table rows: stage, cross the boundary, then sample each slot's last drive cycle.
      for (int r = 0; r < 4; r++) begin
         load_pulse(rows[r].dig, rows[r].dp, rows[r].en);
         run_to(NS - 1);
         for (int k = 0; k < ND; k++) begin
            logic [3:0] xa; logic [6:0] xs; logic xd;
            run_to(k * SC + SC - 1);
            xa = 4'hF; xs = 7'h7F; xd = 1'b1;
            if (rows[r].en[k]) begin
               xa = ~(4'b0001 << k);
               xs = rows[r].seg[k];
               xd = ~rows[r].dp[k];
            end
            chk($sformatf("row%0d_dig%0d", r, k), {bus.o_an, bus.o_seg, bus.o_dp}, {xa, xs, xd});
         end
      end

      // Frame-done spacing.
      t0 = -1; t1 = -1;
      for (int i = 0; i < 3 * NS && t1 < 0; i++) begin
         step();
         if (bus.o_frame_done === 1'b1) begin
            if (t0 < 0) t0 = edges; else t1 = edges;
         end
      end
      chk("frame_done_period", t1 - t0, NS);

      // Mid-frame load must not disturb the running frame.
      run_to(SC + 1);
      load_pulse(16'h5555, 4'h0, 4'hF);
      run_to(2 * SC + SC - 1);
      chk("midload_old_frame", {25'd0, bus.o_seg}, {25'd0, 7'h08});
      run_to(NS - 1);
      run_to(SC - 1);
      chk("midload_next_frame", {25'd0, bus.o_seg}, {25'd0, 7'h12});

      // Load on the boundary cycle overrides a previously staged value.
      run_to(SC + 1);
      load_pulse(16'h1111, 4'h0, 4'hF);
      run_to(NS - 2);
      load_pulse(16'hCCCC, 4'h1, 4'hF);
      run_to(SC - 1);
      chk("bypass_seg", {25'd0, bus.o_seg}, {25'd0, 7'h46});
      chk("bypass_dp", {31'd0, bus.o_dp}, 32'd0);

      // Random loads at random moments, judged by the model every cycle.
      for (int i = 0; i < 1500; i++) begin
         if ($urandom_range(0, 15) == 0)
            set_in(16'($urandom), 4'($urandom), 4'($urandom), 1'b1);
         else
            bus.i_load = 1'b0;
         step();
      end
      bus.i_load = 1'b0;

      // Reset while digit 2 is being driven.
      set_in(16'h3210, 4'h0, 4'hF, 1'b0);
      load_pulse(16'h3210, 4'h0, 4'hF);
      run_to(NS - 1);
      run_to(2 * SC + 4);
      chk("pre_rst_lit", {28'd0, bus.o_an}, {28'd0, 4'b1011});
      #2 rst = 1'b1;
      #1;
      chk("rst_same_cycle", {bus.o_an, bus.o_seg, bus.o_dp, bus.o_frame_done}, {4'hF, 7'h7F, 1'b1, 1'b0});
      model_reset();
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;

      lit = 0;
      for (int i = 0; i < 2 * NS; i++) begin
         step();
         if (bus.o_an !== 4'hF) lit++;
      end
      chk("dark_after_rst", lit, 0);

      load_pulse(16'h9876, 4'b0011, 4'b0110);
      for (int i = 0; i < 2 * NS; i++) step();

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
